// File: rtl/cpu_stack_arb.sv
// cpu_stack_arb: arbitrates the single-port operand stack RAM between
// writeback pushes (stage 5), stage-2 pops and a debug read port.
// Priority is push > pop > debug. A debug request that has waited
// STARVE_MAX cycles outranks a pop for one cycle (stage 2 is stalled).
// A push and pop in the same cycle bypass the RAM entirely.
// Optional macro CPU_STACK_ARB_TRACE_EN prints one line per grant.
module cpu_stack_arb #(
  parameter int DATA_W     = 35,
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_5a,
  input  logic [DATA_W-1:0] push_data_5a,
  input  logic              pop_2a,
  output logic              pop_valid_3a,
  output logic [DATA_W-1:0] pop_data_3a,
  output logic              stall_2a,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W:0]   sp,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Starvation counter saturates at the limit so a preempted override retries.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= STARVE_LIM) ? c : c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  starve_cnt;
  logic              full, empty, dbg_ok, override;
  logic              byp_p0, push_wr_p0, push_ovf_p0, pop_acc_p0;
  logic              pop_rd_p0, pop_unf_p0, dbg_rd_p0;
  logic [ADDR_W-1:0] pop_addr;
  logic              pop_vld_p1, pop_ram_p1, dbg_vld_p1;
  logic [DATA_W-1:0] pop_byp_p1;

  // Stage p0: decide the single RAM grant for this cycle.
  always_comb begin
    full        = sp[ADDR_W];
    empty       = (sp == '0);
    pop_addr    = sp[ADDR_W-1:0] - ADDR_W'(1);
    // A debug read already in flight blocks a second grant while req is held.
    dbg_ok      = !rst && dbg_req && !dbg_vld_p1;
    override    = dbg_ok && (starve_cnt == STARVE_LIM);
    byp_p0      = !rst && push_5a && pop_2a;
    push_wr_p0  = !rst && push_5a && !pop_2a && !full;
    push_ovf_p0 = !rst && push_5a && !pop_2a && full;
    stall_2a    = !rst && pop_2a && !push_5a && override;
    pop_acc_p0  = !rst && pop_2a && !push_5a && !override;
    pop_rd_p0   = pop_acc_p0 && !empty;
    pop_unf_p0  = pop_acc_p0 && empty;
    dbg_rd_p0   = dbg_ok && !push_5a && !pop_acc_p0;

    ram_en    = push_wr_p0 || pop_rd_p0 || dbg_rd_p0;
    ram_we    = push_wr_p0;
    ram_wdata = push_wr_p0 ? push_data_5a : '0;
    if (push_wr_p0)     ram_addr = sp[ADDR_W-1:0];
    else if (pop_rd_p0) ram_addr = pop_addr;
    else if (dbg_rd_p0) ram_addr = dbg_addr;
    else                ram_addr = '0;
  end

  // Stage p0 -> p1: stack pointer, sticky flags, starvation count, result valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp         <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      starve_cnt <= '0;
      pop_vld_p1 <= 1'b0;
      pop_ram_p1 <= 1'b0;
      dbg_vld_p1 <= 1'b0;
    end else begin
      if (push_wr_p0)     sp <= sp + (ADDR_W+1)'(1);
      else if (pop_rd_p0) sp <= sp - (ADDR_W+1)'(1);
      if (push_ovf_p0) overflow  <= 1'b1;
      if (pop_unf_p0)  underflow <= 1'b1;
      pop_vld_p1 <= byp_p0 || pop_acc_p0;
      pop_ram_p1 <= pop_rd_p0;
      dbg_vld_p1 <= dbg_rd_p0;
      if (dbg_rd_p0 || dbg_vld_p1) starve_cnt <= '0;
      else if (dbg_req)            starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Stage p1 data: bypassed push data, or zero for an empty pop.
  always_ff @(posedge clk) begin
    if (byp_p0)          pop_byp_p1 <= push_data_5a;
    else if (pop_unf_p0) pop_byp_p1 <= '0;
  end

  // Stage p1: deliver read results; reset discards anything in flight.
  always_comb begin
    pop_valid_3a = pop_vld_p1 && !rst;
    dbg_ack      = dbg_vld_p1 && !rst;
    if (!pop_valid_3a)   pop_data_3a = '0;
    else if (pop_ram_p1) pop_data_3a = ram_rdata;
    else                 pop_data_3a = pop_byp_p1;
    dbg_data = dbg_ack ? ram_rdata : '0;
  end

`ifdef CPU_STACK_ARB_TRACE_EN
  // Log each grant on the edge that commits it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_wr_p0)
        $display("%0d PUSH addr=%0h data=%0h sp=%0d", $stime, ram_addr, push_data_5a, sp);
      if (pop_acc_p0)
        $display("%0d POP addr=%0h data=%0h sp=%0d", $stime, ram_addr, ram_rdata, sp);
      if (byp_p0)
        $display("%0d BYP addr=%0h data=%0h sp=%0d", $stime, ram_addr, push_data_5a, sp);
      if (dbg_rd_p0)
        $display("%0d DBG addr=%0h data=%0h sp=%0d", $stime, ram_addr, ram_rdata, sp);
    end
  end
`else
  // Trace disabled: the design produces no simulation output.
`endif

endmodule

// File: tb/tb_cpu_stack_arb.sv
// Testbench for cpu_stack_arb: directed scenarios followed by randomized
// traffic checked against a behavioural stack model.
module tb_cpu_stack_arb;

  localparam int DATA_W     = 35;
  localparam int ADDR_W     = 10;
  localparam int STARVE_MAX = 8;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              push_5a;
  logic [DATA_W-1:0] push_data_5a;
  logic              pop_2a;
  logic              pop_valid_3a;
  logic [DATA_W-1:0] pop_data_3a;
  logic              stall_2a;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W:0]   sp;
  logic              overflow;
  logic              underflow;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] ram_q   [DEPTH];
  logic [DATA_W-1:0] mdl_mem [DEPTH];

  int n_pass  = 0;
  int n_total = 0;

  cpu_stack_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .push_5a(push_5a), .push_data_5a(push_data_5a),
    .pop_2a(pop_2a), .pop_valid_3a(pop_valid_3a), .pop_data_3a(pop_data_3a),
    .stall_2a(stall_2a),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .sp(sp), .overflow(overflow), .underflow(underflow),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM macro stand-in.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_q[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_q[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_5a = 1'b0; push_data_5a = '0; pop_2a = 1'b0; dbg_req = 1'b0; dbg_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick();
    @(negedge clk);
    n_total++; if (sp !== '0) $display("FAIL reset_sp: got %0d want 0", sp); else n_pass++;
    n_total++; if ({pop_valid_3a, dbg_ack, stall_2a} !== 3'b000)
      $display("FAIL reset_valids: got %b want 000", {pop_valid_3a, dbg_ack, stall_2a}); else n_pass++;
    n_total++; if ({overflow, underflow} !== 2'b00)
      $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); else n_pass++;
    n_total++; if ({ram_en, ram_we} !== 2'b00)
      $display("FAIL reset_ram: got %b want 00", {ram_en, ram_we}); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push_seq();
    for (int i = 0; i < 3; i++) begin
      push_5a = 1'b1; push_data_5a = DATA_W'(i + 1);
      @(negedge clk);
      n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, ADDR_W'(i)})
        $display("FAIL push_access[%0d]: got en=%b we=%b addr=%0h want 1 1 %0h", i, ram_en, ram_we, ram_addr, i); else n_pass++;
      n_total++; if (ram_wdata !== DATA_W'(i + 1))
        $display("FAIL push_wdata[%0d]: got %0h want %0h", i, ram_wdata, i + 1); else n_pass++;
      n_total++; if (stall_2a !== 1'b0) $display("FAIL push_stall[%0d]: got %b want 0", i, stall_2a); else n_pass++;
      tick();
    end
    idle();
    @(negedge clk);
    n_total++; if (sp !== 11'd3) $display("FAIL push_sp: got %0d want 3", sp); else n_pass++;
    tick();
  endtask

  task automatic test_pop_seq();
    for (int k = 0; k < 4; k++) begin
      pop_2a = 1'b1;
      @(negedge clk);
      if (k < 3) begin
        n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, ADDR_W'(2 - k)})
          $display("FAIL pop_access[%0d]: got en=%b we=%b addr=%0h want 1 0 %0h", k, ram_en, ram_we, ram_addr, 2 - k); else n_pass++;
      end else begin
        n_total++; if (ram_en !== 1'b0) $display("FAIL pop_empty_noread: got %b want 0", ram_en); else n_pass++;
        n_total++; if (sp !== '0) $display("FAIL pop_sp: got %0d want 0", sp); else n_pass++;
      end
      if (k > 0) begin
        n_total++; if ({pop_valid_3a, pop_data_3a} !== {1'b1, DATA_W'(4 - k)})
          $display("FAIL pop_data[%0d]: got v=%b d=%0h want 1 %0h", k, pop_valid_3a, pop_data_3a, 4 - k); else n_pass++;
      end
      n_total++; if (stall_2a !== 1'b0) $display("FAIL pop_stall[%0d]: got %b want 0", k, stall_2a); else n_pass++;
      tick();
    end
    idle();
    @(negedge clk);
    n_total++; if ({pop_valid_3a, pop_data_3a} !== {1'b1, DATA_W'(0)})
      $display("FAIL underflow_data: got v=%b d=%0h want 1 0", pop_valid_3a, pop_data_3a); else n_pass++;
    n_total++; if (underflow !== 1'b1) $display("FAIL underflow_flag: got %b want 1", underflow); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (pop_valid_3a !== 1'b0) $display("FAIL pop_valid_idle: got %b want 0", pop_valid_3a); else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    do_reset();
    push_5a = 1'b1; pop_2a = 1'b1; push_data_5a = DATA_W'('h123);
    @(negedge clk);
    n_total++; if ({ram_en, stall_2a} !== 2'b00)
      $display("FAIL byp_empty_access: got en=%b stall=%b want 0 0", ram_en, stall_2a); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_total++; if ({pop_valid_3a, pop_data_3a} !== {1'b1, DATA_W'('h123)})
      $display("FAIL byp_empty_data: got v=%b d=%0h want 1 123", pop_valid_3a, pop_data_3a); else n_pass++;
    n_total++; if ({sp, overflow, underflow} !== {11'd0, 2'b00})
      $display("FAIL byp_empty_state: got sp=%0d ovf=%b unf=%b want 0 0 0", sp, overflow, underflow); else n_pass++;
    tick();
    push_5a = 1'b1; push_data_5a = DATA_W'('hA); tick();
    push_data_5a = DATA_W'('hB); tick();
    pop_2a = 1'b1; push_data_5a = DATA_W'('h7FF);
    @(negedge clk);
    n_total++; if ({ram_en, stall_2a} !== 2'b00)
      $display("FAIL byp_access: got en=%b stall=%b want 0 0", ram_en, stall_2a); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_total++; if ({pop_valid_3a, pop_data_3a} !== {1'b1, DATA_W'('h7FF)})
      $display("FAIL byp_data: got v=%b d=%0h want 1 7ff", pop_valid_3a, pop_data_3a); else n_pass++;
    n_total++; if (sp !== 11'd2) $display("FAIL byp_sp: got %0d want 2", sp); else n_pass++;
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_5a = 1'b1; push_data_5a = DATA_W'(i + 100);
      tick();
    end
    push_data_5a = DATA_W'(5);
    @(negedge clk);
    n_total++; if (ram_en !== 1'b0) $display("FAIL ovf_noaccess: got %b want 0", ram_en); else n_pass++;
    n_total++; if (sp !== 11'd1024) $display("FAIL full_sp: got %0d want 1024", sp); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_total++; if ({overflow, sp} !== {1'b1, 11'd1024})
      $display("FAIL ovf_flag: got ovf=%b sp=%0d want 1 1024", overflow, sp); else n_pass++;
    tick();
    pop_2a = 1'b1;
    @(negedge clk);
    n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 10'd1023})
      $display("FAIL full_pop_access: got en=%b we=%b addr=%0d want 1 0 1023", ram_en, ram_we, ram_addr); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_total++; if ({pop_valid_3a, pop_data_3a} !== {1'b1, DATA_W'(1123)})
      $display("FAIL full_pop_data: got v=%b d=%0d want 1 1123", pop_valid_3a, pop_data_3a); else n_pass++;
    n_total++; if (sp !== 11'd1023) $display("FAIL full_pop_sp: got %0d want 1023", sp); else n_pass++;
    tick();
  endtask

  task automatic test_debug_starve();
    int s;
    s = 1023;
    dbg_req = 1'b1; dbg_addr = 10'd4; pop_2a = 1'b1;
    for (int c = 0; c < STARVE_MAX; c++) begin
      @(negedge clk);
      n_total++; if ({stall_2a, dbg_ack} !== 2'b00)
        $display("FAIL starve_wait[%0d]: got stall=%b ack=%b want 0 0", c, stall_2a, dbg_ack); else n_pass++;
      n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, ADDR_W'(s - 1 - c)})
        $display("FAIL starve_pop_addr[%0d]: got %0d want %0d", c, ram_addr, s - 1 - c); else n_pass++;
      if (c > 0) begin
        n_total++; if ({pop_valid_3a, pop_data_3a} !== {1'b1, DATA_W'(s - c + 100)})
          $display("FAIL starve_pop_data[%0d]: got v=%b d=%0d want 1 %0d", c, pop_valid_3a, pop_data_3a, s - c + 100); else n_pass++;
      end
      tick();
    end
    @(negedge clk);
    n_total++; if (stall_2a !== 1'b1) $display("FAIL starve_stall: got %b want 1", stall_2a); else n_pass++;
    n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 10'd4})
      $display("FAIL dbg_grant: got en=%b we=%b addr=%0d want 1 0 4", ram_en, ram_we, ram_addr); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({dbg_ack, dbg_data} !== {1'b1, DATA_W'(104)})
      $display("FAIL dbg_ack_data: got ack=%b d=%0d want 1 104", dbg_ack, dbg_data); else n_pass++;
    n_total++; if ({pop_valid_3a, stall_2a} !== 2'b00)
      $display("FAIL dbg_cycle_pop: got v=%b stall=%b want 0 0", pop_valid_3a, stall_2a); else n_pass++;
    n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, ADDR_W'(s - 9)})
      $display("FAIL retry_pop_addr: got %0d want %0d", ram_addr, s - 9); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_total++; if ({pop_valid_3a, pop_data_3a} !== {1'b1, DATA_W'(s - 9 + 100)})
      $display("FAIL retry_pop_data: got v=%b d=%0d want 1 %0d", pop_valid_3a, pop_data_3a, s - 9 + 100); else n_pass++;
    n_total++; if ({dbg_ack, sp} !== {1'b0, 11'(s - 9)})
      $display("FAIL retry_state: got ack=%b sp=%0d want 0 %0d", dbg_ack, sp, s - 9); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midop();
    pop_2a = 1'b1;
    tick();
    rst = 1'b1; idle();
    tick();
    @(negedge clk);
    n_total++; if ({pop_valid_3a, sp} !== {1'b0, 11'd0})
      $display("FAIL midrst_pop: got v=%b sp=%0d want 0 0", pop_valid_3a, sp); else n_pass++;
    n_total++; if ({overflow, underflow} !== 2'b00)
      $display("FAIL midrst_flags: got %b want 00", {overflow, underflow}); else n_pass++;
    rst = 1'b0;
    tick();
    dbg_req = 1'b1; dbg_addr = 10'd7;
    @(negedge clk);
    n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 10'd7})
      $display("FAIL idle_dbg_grant: got en=%b we=%b addr=%0d want 1 0 7", ram_en, ram_we, ram_addr); else n_pass++;
    tick();
    rst = 1'b1; idle();
    tick();
    @(negedge clk);
    n_total++; if (dbg_ack !== 1'b0) $display("FAIL midrst_dbg: got %b want 0", dbg_ack); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int msp, mwait;
    logic movf, munf, e_ovf, e_unf;
    logic e_en, e_we, e_stall, grant_dbg, dbg_can, ack_seen;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    logic [ADDR_W:0]   e_sp;
    logic exp_pv, exp_da, n_pv, n_da;
    logic [DATA_W-1:0] exp_pd, exp_dd, n_pd, n_dd;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = DATA_W'(i + 100);
    do_reset();
    msp = 0; mwait = 0; movf = 1'b0; munf = 1'b0; ack_seen = 1'b0;
    exp_pv = 1'b0; exp_da = 1'b0; exp_pd = '0; exp_dd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ack_seen) dbg_req = 1'b0;
      push_5a      = ($urandom_range(0, 9) < 4);
      push_data_5a = DATA_W'({$urandom(), $urandom()});
      pop_2a       = ($urandom_range(0, 9) < 5);
      if (!dbg_req && $urandom_range(0, 9) == 0) begin
        dbg_req = 1'b1; dbg_addr = ADDR_W'($urandom());
      end
      e_sp = (ADDR_W+1)'(msp); e_ovf = movf; e_unf = munf;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_stall = 1'b0;
      n_pv = 1'b0; n_pd = '0; n_da = 1'b0; n_dd = '0; grant_dbg = 1'b0;
      dbg_can = dbg_req && !exp_da;
      if (push_5a && pop_2a) begin
        n_pv = 1'b1; n_pd = push_data_5a;
      end else if (push_5a) begin
        if (msp < DEPTH) begin
          e_en = 1'b1; e_we = 1'b1; e_addr = ADDR_W'(msp); e_wd = push_data_5a;
          mdl_mem[msp] = push_data_5a; msp++;
        end else movf = 1'b1;
      end else if (pop_2a && dbg_can && mwait >= STARVE_MAX) begin
        e_stall = 1'b1; grant_dbg = 1'b1;
      end else if (pop_2a) begin
        n_pv = 1'b1;
        if (msp > 0) begin
          msp--; e_en = 1'b1; e_addr = ADDR_W'(msp); n_pd = mdl_mem[msp];
        end else munf = 1'b1;
      end else if (dbg_can) grant_dbg = 1'b1;
      if (grant_dbg) begin
        e_en = 1'b1; e_addr = dbg_addr; n_da = 1'b1; n_dd = mdl_mem[dbg_addr];
      end
      @(negedge clk);
      n_total++; if (ram_en !== e_en) $display("FAIL rnd_en[%0d]: got %b want %b", cyc, ram_en, e_en); else n_pass++;
      if (e_en) begin
        n_total++; if ({ram_we, ram_addr} !== {e_we, e_addr})
          $display("FAIL rnd_access[%0d]: got we=%b addr=%0h want %b %0h", cyc, ram_we, ram_addr, e_we, e_addr); else n_pass++;
      end
      if (e_we) begin
        n_total++; if (ram_wdata !== e_wd) $display("FAIL rnd_wdata[%0d]: got %0h want %0h", cyc, ram_wdata, e_wd); else n_pass++;
      end
      n_total++; if (stall_2a !== e_stall) $display("FAIL rnd_stall[%0d]: got %b want %b", cyc, stall_2a, e_stall); else n_pass++;
      n_total++; if (pop_valid_3a !== exp_pv) $display("FAIL rnd_pop_valid[%0d]: got %b want %b", cyc, pop_valid_3a, exp_pv); else n_pass++;
      if (exp_pv) begin
        n_total++; if (pop_data_3a !== exp_pd) $display("FAIL rnd_pop_data[%0d]: got %0h want %0h", cyc, pop_data_3a, exp_pd); else n_pass++;
      end
      n_total++; if (dbg_ack !== exp_da) $display("FAIL rnd_dbg_ack[%0d]: got %b want %b", cyc, dbg_ack, exp_da); else n_pass++;
      if (exp_da) begin
        n_total++; if (dbg_data !== exp_dd) $display("FAIL rnd_dbg_data[%0d]: got %0h want %0h", cyc, dbg_data, exp_dd); else n_pass++;
      end
      n_total++; if ({sp, overflow, underflow} !== {e_sp, e_ovf, e_unf})
        $display("FAIL rnd_state[%0d]: got sp=%0d ovf=%b unf=%b want %0d %b %b", cyc, sp, overflow, underflow, e_sp, e_ovf, e_unf); else n_pass++;
      if (grant_dbg || exp_da) mwait = 0;
      else if (dbg_req && mwait < STARVE_MAX) mwait++;
      ack_seen = exp_da;
      exp_pv = n_pv; exp_pd = n_pd; exp_da = n_da; exp_dd = n_dd;
      tick();
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_push_seq();
    test_pop_seq();
    test_bypass();
    test_overflow();
    test_debug_starve();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
